// File: rtl/store_checker_pkg.sv
// Shared definitions for the store checker.
// Provides the FSM state encoding, the verdict codes reported on fail_code
// and a helper that sizes the table index port.
package store_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } state_t;

  localparam logic [1:0] FC_NONE      = 2'd0;  // no verdict, or PASS
  localparam logic [1:0] FC_BAD_STORE = 2'd1;  // wrong data, or store to an unexpected address
  localparam logic [1:0] FC_TIMEOUT   = 2'd2;  // cycle budget ran out
  localparam logic [1:0] FC_ORDER     = 2'd3;  // duplicate or out-of-order hit

  // The index port is at least one bit wide, even for a single-entry table.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/store_checker_if.sv
// Data-memory write port of the core, as seen by the store checker.
//   memwrite   store strobe
//   dataadr    store address
//   writedata  store data
// The core side uses the master modport. The checker uses the slave modport,
// so it only observes the port.
interface store_checker_if #(
  parameter int WIDTH = 32
);

  logic             memwrite;
  logic [WIDTH-1:0] dataadr;
  logic [WIDTH-1:0] writedata;

  modport master (output memwrite, output dataadr, output writedata);
  modport slave  (input  memwrite, input  dataadr, input  writedata);

endinterface

// File: rtl/store_match.sv
// Combinational lookup of one store against the expected-store table.
//   dataadr, writedata   the store being checked
//   tbl_addr, tbl_data   expected (address, data) per entry
//   hits                 entries already matched in this run
//   match_oh             one-hot: the entry this store legally hits (lowest index wins)
//   addr_hit             store address equals some entry address
//   data_hit             store address and data both equal some entry
// When ORDERED is set, an entry is only legal once every lower entry has been hit.
module store_match #(
  parameter int WIDTH   = 32,
  parameter int NCHECK  = 4,
  parameter bit ORDERED = 1'b1
) (
  input  logic [WIDTH-1:0]  dataadr,
  input  logic [WIDTH-1:0]  writedata,
  input  logic [WIDTH-1:0]  tbl_addr [NCHECK],
  input  logic [WIDTH-1:0]  tbl_data [NCHECK],
  input  logic [NCHECK-1:0] hits,
  output logic [NCHECK-1:0] match_oh,
  output logic              addr_hit,
  output logic              data_hit
);

  logic [NCHECK-1:0] a_eq;
  logic [NCHECK-1:0] d_eq;
  logic [NCHECK-1:0] legal;
  logic              prefix_hit;

  // NOTE: every output of a combinational block gets a default before any
  // conditional code. Without that default, synthesis infers a latch.
  always_comb begin
    a_eq = '0;
    d_eq = '0;
    for (int i = 0; i < NCHECK; i++) begin
      a_eq[i] = (tbl_addr[i] == dataadr);
      d_eq[i] = (tbl_data[i] == writedata);
    end
  end

  // prefix_hit is true while all entries below i are already hit. That
  // condition is the in-order requirement.
  always_comb begin
    legal      = '0;
    prefix_hit = 1'b1;
    for (int i = 0; i < NCHECK; i++) begin
      legal[i]   = a_eq[i] && d_eq[i] && !hits[i] && (!ORDERED || prefix_hit);
      prefix_hit = prefix_hit && hits[i];
    end
  end

  // Scan from the top down so that the lowest legal index overwrites the rest.
  // This resolves duplicate table entries.
  always_comb begin
    match_oh = '0;
    for (int i = NCHECK - 1; i >= 0; i--) begin
      if (legal[i]) begin
        match_oh    = '0;
        match_oh[i] = 1'b1;
      end
    end
  end

  assign addr_hit = |a_eq;
  assign data_hit = |(a_eq & d_eq);

endmodule

// File: rtl/store_checker.sv
// Self-checking monitor on the MIPS data-memory write port.
// It holds NCHECK expected (address, data) stores and tolerates writes into
// the scratch window [SCR_LO, SCR_HI].
// Verdicts: PASS once every entry is hit, FAIL on the first illegal store,
// TIMEOUT after MAX_CYCLES RUN cycles (MAX_CYCLES = 0 disables the timeout).
// Ports:
//   clk, reset            rising-edge clock; asynchronous active-high reset
//   cfg_we/idx/addr/data  table write, accepted only in IDLE
//   start                 enter RUN from any state; clears hits, counters and capture
//   bus                   observed store port (memwrite, dataadr, writedata)
//   done, pass            verdict flags (done in PASS/FAIL/TIMEOUT, pass in PASS only)
//   fail_code             0 none, 1 bad store, 2 timeout, 3 duplicate/out-of-order
//   fail_addr/fail_data   the offending store, captured once
//   hits                  bitmap of matched entries
//   store_cnt             stores seen in RUN, saturating
module store_checker
  import store_checker_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int NCHECK     = 4,
  parameter bit ORDERED    = 1'b1,
  parameter int MAX_CYCLES = 4096,
  parameter int SCR_LO     = 80,
  parameter int SCR_HI     = 80,
  localparam int IW        = idx_width(NCHECK)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [IW-1:0]     cfg_idx,
  input  logic [WIDTH-1:0]  cfg_addr,
  input  logic [WIDTH-1:0]  cfg_data,
  input  logic              start,
  store_checker_if.slave    bus,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_code,
  output logic [WIDTH-1:0]  fail_addr,
  output logic [WIDTH-1:0]  fail_data,
  output logic [NCHECK-1:0] hits,
  output logic [15:0]       store_cnt
);

  typedef struct packed {
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] data;
  } entry_t;

  localparam logic [WIDTH-1:0] SCR_LO_W = WIDTH'(SCR_LO);
  localparam logic [WIDTH-1:0] SCR_HI_W = WIDTH'(SCR_HI);
  localparam logic [31:0]      CYC_LAST = (MAX_CYCLES > 0) ? 32'(MAX_CYCLES - 1) : 32'd0;

  state_t            state_q, state_d;
  logic [NCHECK-1:0] hits_q, hits_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [31:0]       cyc_q, cyc_d;
  logic [1:0]        fc_q, fc_d;
  logic [WIDTH-1:0]  fa_q, fa_d;
  logic [WIDTH-1:0]  fd_q, fd_d;

  entry_t            entries_q [NCHECK];
  logic [WIDTH-1:0]  tbl_addr  [NCHECK];
  logic [WIDTH-1:0]  tbl_data  [NCHECK];

  logic [NCHECK-1:0] match_oh;
  logic              addr_hit;
  logic              data_hit;
  logic              in_scratch;

  // ------------------------------------------------------------------------
  // Expected-store table
  // ------------------------------------------------------------------------
  // NOTE: the table is storage, not control state, so it has no reset.
  // A reset must not erase a loaded test, and leaving out the reset lets the
  // table map onto plain flops or distributed RAM.
  always_ff @(posedge clk) begin
    if (cfg_we && state_q == ST_IDLE && int'(cfg_idx) < NCHECK) begin
      entries_q[cfg_idx] <= '{addr: cfg_addr, data: cfg_data};
    end
  end

  always_comb begin
    for (int i = 0; i < NCHECK; i++) begin
      tbl_addr[i] = entries_q[i].addr;
      tbl_data[i] = entries_q[i].data;
    end
  end

  store_match #(
    .WIDTH   (WIDTH),
    .NCHECK  (NCHECK),
    .ORDERED (ORDERED)
  ) u_match (
    .dataadr   (bus.dataadr),
    .writedata (bus.writedata),
    .tbl_addr  (tbl_addr),
    .tbl_data  (tbl_data),
    .hits      (hits_q),
    .match_oh  (match_oh),
    .addr_hit  (addr_hit),
    .data_hit  (data_hit)
  );

  assign in_scratch = (bus.dataadr >= SCR_LO_W) && (bus.dataadr <= SCR_HI_W);

  // ------------------------------------------------------------------------
  // FSM and run bookkeeping: state register
  // ------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples the values from before the clock edge, whatever the statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hits_q  <= '0;
      cnt_q   <= '0;
      cyc_q   <= '0;
      fc_q    <= FC_NONE;
      fa_q    <= '0;
      fd_q    <= '0;
    end else begin
      state_q <= state_d;
      hits_q  <= hits_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      fc_q    <= fc_d;
      fa_q    <= fa_d;
      fd_q    <= fd_d;
    end
  end

  // ------------------------------------------------------------------------
  // FSM and run bookkeeping: next state
  // ------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    hits_d  = hits_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    fc_d    = fc_q;
    fa_d    = fa_q;
    fd_d    = fd_q;

    if (start) begin
      // Re-arm from any state. A store in this same cycle is not checked.
      state_d = ST_RUN;
      hits_d  = '0;
      cnt_d   = '0;
      cyc_d   = '0;
      fc_d    = FC_NONE;
      fa_d    = '0;
      fd_d    = '0;
    end else if (state_q == ST_RUN) begin
      if (bus.memwrite) begin
        if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
        if (|match_oh) begin
          hits_d = hits_q | match_oh;
        end else if (addr_hit || !in_scratch) begin
          // The store hits a table address without a legal match, or it
          // falls outside the table and outside the scratch window.
          state_d = ST_FAIL;
          fc_d    = (addr_hit && data_hit) ? FC_ORDER : FC_BAD_STORE;
          fa_d    = bus.dataadr;
          fd_d    = bus.writedata;
        end
      end

      // Completion is checked before expiry, so a final hit on the last
      // budget cycle still passes.
      if (state_d == ST_RUN) begin
        if (&hits_d) begin
          state_d = ST_PASS;
        end else if (MAX_CYCLES > 0 && cyc_q == CYC_LAST) begin
          state_d = ST_TIMEOUT;
          fc_d    = FC_TIMEOUT;
        end else begin
          cyc_d = cyc_q + 32'd1;
        end
      end
    end
  end

  assign done      = (state_q == ST_PASS) || (state_q == ST_FAIL) || (state_q == ST_TIMEOUT);
  assign pass      = (state_q == ST_PASS);
  assign fail_code = fc_q;
  assign fail_addr = fa_q;
  assign fail_data = fd_q;
  assign hits      = hits_q;
  assign store_cnt = cnt_q;

endmodule
